// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/subtract unit.
package cla_pkg;

    // Mode encoding for the sub input.
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Number of pipeline stages; 0 flags an unusable parameter set.
    function automatic int cla_nseg(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 0;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result bus of the pipelined adder.
//
// Handshake: a beat moves across an edge exactly when valid & ready are both
// high in the cycle before it. in_ready never depends on in_valid, and a
// presented result (out_valid=1) keeps sum/cout/ovf stable until out_ready.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder_seg.sv
// Combinational SEG-bit carry-lookahead slice. c_msb is the carry into the
// slice MSB, which the top slice needs for signed overflow.
module cla_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is expanded directly from g/p/cin (no ripple through c).
    always_comb begin
        logic gg;
        logic pp;
        c    = '0;
        c[0] = cin;
        gg   = 1'b0;
        pp   = 1'b1;
        for (int i = 0; i < SEG; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gg = gg | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = gg | (pp & cin);
        end
    end

    assign sum   = p ^ c[SEG-1:0];
    assign cout  = c[SEG];
    assign c_msb = c[SEG-1];
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract: stage k resolves slice k, carries into stage k+1,
// skews the still-unused upper operand bits forward and accumulates the
// finished lower sum bits so the result leaves aligned after NSEG stages.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input logic             clk,
    input logic             rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int NSEG = cla_nseg(WIDTH, SEG);

    if (SEG < 1 || NSEG < 1 || NSEG * SEG != WIDTH) begin : g_bad_params
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of SEG");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // One enable for the whole pipe: move unless a result is being held.
    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

    // Subtraction is a + ~b + 1; cin only matters for addition.
    assign b_eff = (bus.sub == SUB) ? ~bus.b : bus.b;
    assign c0    = (bus.sub == SUB) ? 1'b1 : bus.cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int UP = (NSEG - 1 - k) * SEG;  // operand bits above slice k
        localparam int LO = k * SEG;               // sum bits already resolved

        logic [UP+SEG-1:0] a_rem;
        logic [UP+SEG-1:0] b_rem;
        logic              v_in;
        logic              c_in;
        logic [SEG-1:0]    seg_sum;
        logic              seg_cout;
        logic              seg_cmsb;
        logic              v_q;
        logic              c_q;
        logic [LO+SEG-1:0] s_q;

        if (k == 0) begin : g_in
            assign a_rem = bus.a;
            assign b_rem = b_eff;
            assign v_in  = bus.in_valid;
            assign c_in  = c0;
        end else begin : g_in
            assign a_rem = g_stage[k-1].g_skew.a_q;
            assign b_rem = g_stage[k-1].g_skew.b_q;
            assign v_in  = g_stage[k-1].v_q;
            assign c_in  = g_stage[k-1].c_q;
        end

        cla_seg #(.SEG(SEG)) u_seg (
            .a     (a_rem[SEG-1:0]),
            .b     (b_rem[SEG-1:0]),
            .cin   (c_in),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .c_msb (seg_cmsb)
        );

        // Stage valid bit and the carry handed to the next slice.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= seg_cout;
            end
        end

        if (k == 0) begin : g_sum
            // Deskew: first resolved slice.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) s_q <= '0;
                else if (adv) s_q <= seg_sum;
            end
        end else begin : g_sum
            // Deskew: append this slice above the slices already resolved.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) s_q <= '0;
                else if (adv) s_q <= {seg_sum, g_stage[k-1].s_q};
            end
        end

        if (UP > 0) begin : g_skew
            logic [UP-1:0] a_q;
            logic [UP-1:0] b_q;
            // Skew: carry the untouched upper operand bits to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_rem[UP+SEG-1:SEG];
                    b_q <= b_rem[UP+SEG-1:SEG];
                end
            end
        end

        if (k == NSEG - 1) begin : g_ovf
            logic o_q;
            // Signed overflow from the carries into and out of the word MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) o_q <= 1'b0;
                else if (adv) o_q <= seg_cout ^ seg_cmsb;
            end
        end else begin : g_no_ovf
            // Only the top slice's MSB carry has a meaning for overflow.
            logic cmsb_unused;
            assign cmsb_unused = seg_cmsb;
        end
    end

    assign bus.out_valid = g_stage[NSEG-1].v_q;
    assign bus.sum       = g_stage[NSEG-1].s_q;
    assign bus.cout      = g_stage[NSEG-1].c_q;
    assign bus.ovf       = g_stage[NSEG-1].g_ovf.o_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed corner cases, random back-to-back ops,
// backpressure, mid-stream reset and a (WIDTH,SEG) sweep.
module tb_cla_pipe_adder;
    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int NSEG  = WIDTH / SEG;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain w-bit two's complement arithmetic -> {ovf, cout, sum}.
    function automatic logic [65:0] ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic cin, input logic sub);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] am;
        logic [63:0] bb;
        logic [63:0] s;
        logic        c0;
        logic        co;
        logic        ov;
        mask = (65'd1 << w) - 65'd1;
        am   = a & mask[63:0];
        bb   = (sub ? ~b : b) & mask[63:0];
        c0   = sub ? 1'b1 : cin;
        full = {1'b0, am} + {1'b0, bb} + {64'd0, c0};
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    // ---------------- scoreboard ----------------
    logic [65:0] exp_q[$];
    int          t_q[$];
    int          n_in    = 0;
    int          n_out   = 0;
    bit          lat_chk = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_op(WIDTH, 64'(bus.a), 64'(bus.b), bus.cin, bus.sub));
                t_q.push_back(cyc);
                n_in++;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 66'd1, 66'd0);
                end else begin
                    check_eq("result", {bus.ovf, bus.cout, 32'd0, bus.sum}, exp_q.pop_front());
                    if (lat_chk) check_eq("latency", 66'(cyc - t_q.pop_front()), 66'(NSEG));
                    else void'(t_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
    endtask

    task automatic drive_rand();
        drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic run_directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub, input logic [31:0] exp_sum,
                                input logic exp_cout, input logic exp_ovf);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        drive(1'b1, a, b, cin, sub);
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (i == 0) bus.in_valid = 1'b0;
            lat++;
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, 66'(seen), 66'd1);
        check_eq({tag, "_lat"}, 66'(lat), 66'(NSEG));
        check_eq({tag, "_sum"}, 66'(bus.sum), 66'(exp_sum));
        check_eq({tag, "_cout"}, 66'(bus.cout), 66'(exp_cout));
        check_eq({tag, "_ovf"}, 66'(bus.ovf), 66'(exp_ovf));
        step();
    endtask

    // ---------------- parameter sweep instances ----------------
    bit sweep_go = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int W  = (g == 2) ? 64 : 16;
        localparam int S  = (g == 0) ? 16 : ((g == 1) ? 8 : 4);
        localparam int NS = W / S;

        cla_pipe_adder_if #(.WIDTH(W)) sbus ();

        cla_pipe_adder #(.WIDTH(W), .SEG(S)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sbus)
        );

        logic [65:0] sq[$];
        int          st[$];
        bit          done = 1'b0;

        initial begin
            logic [63:0] ra;
            logic [63:0] rb;
            sbus.in_valid  = 1'b0;
            sbus.a         = '0;
            sbus.b         = '0;
            sbus.cin       = 1'b0;
            sbus.sub       = 1'b0;
            sbus.out_ready = 1'b1;
            wait (sweep_go);
            @(posedge clk);
            #1;
            for (int i = 0; i < 80; i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (i % 8 == 0) begin
                    ra = '1;
                    rb = '0;
                end
                sbus.in_valid = (i % 8 == 0) || ($urandom_range(0, 3) != 0);
                sbus.a        = ra[W-1:0];
                sbus.b        = rb[W-1:0];
                sbus.cin      = (i % 8 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                sbus.sub      = (i % 8 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            sbus.in_valid = 1'b0;
            repeat (NS + 4) @(posedge clk);
            #1;
            check_eq($sformatf("sweep%0d_drained", g), 66'(sq.size()), 66'd0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (rst_n && sweep_go) begin
                if (sbus.in_valid && sbus.in_ready) begin
                    sq.push_back(ref_op(W, 64'(sbus.a), 64'(sbus.b), sbus.cin, sbus.sub));
                    st.push_back(cyc);
                end
                if (sbus.out_valid && sbus.out_ready) begin
                    if (sq.size() == 0) begin
                        check_eq($sformatf("sweep%0d_spurious", g), 66'd1, 66'd0);
                    end else begin
                        check_eq($sformatf("sweep%0d_result", g),
                                 {sbus.ovf, sbus.cout, 64'(sbus.sum)}, sq.pop_front());
                        check_eq($sformatf("sweep%0d_lat", g), 66'(cyc - st.pop_front()), 66'(NS));
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int base_in;
        int base_out;
        bit all_done;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 66'(bus.out_valid), 66'd0);
        check_eq("rst_sum", 66'(bus.sum), 66'd0);
        check_eq("rst_in_ready", 66'(bus.in_ready), 66'd1);
        step();
        rst_n = 1'b1;
        step();

        // Directed corners
        run_directed("carry_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        run_directed("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_directed("sub_borrow", 32'h0, 32'h1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_directed("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_directed("sub_cin_ignored", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);

        // Back-to-back random ops, no stalls
        base_in  = n_in;
        base_out = n_out;
        for (int i = 0; i < 100; i++) begin
            drive_rand();
            step();
        end
        bus.in_valid = 1'b0;
        repeat (NSEG + 2) step();
        check_eq("b2b_accepted", 66'(n_in - base_in), 66'd100);
        check_eq("b2b_emitted", 66'(n_out - base_out), 66'd100);
        check_eq("b2b_drained", 66'(exp_q.size()), 66'd0);

        // Backpressure with a full pipe
        lat_chk  = 1'b0;
        base_in  = n_in;
        base_out = n_out;
        for (int i = 0; i < NSEG; i++) begin
            drive_rand();
            step();
        end
        bus.out_ready = 1'b0;
        drive_rand();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 66'(bus.in_ready), 66'd0);
            check_eq("bp_out_valid", 66'(bus.out_valid), 66'd1);
            if (exp_q.size() == 0) check_eq("bp_expected_present", 66'd0, 66'd1);
            else check_eq("bp_held", {bus.ovf, bus.cout, 32'd0, bus.sum}, exp_q[0]);
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_rand();
            step();
        end
        bus.in_valid = 1'b0;
        repeat (NSEG + 2) step();
        check_eq("bp_accepted", 66'(n_in - base_in), 66'(NSEG + 6));
        check_eq("bp_no_loss", 66'(n_out - base_out), 66'(NSEG + 6));
        check_eq("bp_drained", 66'(exp_q.size()), 66'd0);

        // Reset with ops in flight and one result held at the output
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'h11, 1'b0, 1'b0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_eq("pre_rst_valid", 66'(bus.out_valid), 66'd1);
        check_eq("pre_rst_sum", 66'(bus.sum), 66'h111);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_out_valid", 66'(bus.out_valid), 66'd0);
        check_eq("rst_mid_sum", 66'(bus.sum), 66'd0);
        check_eq("rst_mid_cout", 66'(bus.cout), 66'd0);
        check_eq("rst_mid_ovf", 66'(bus.ovf), 66'd0);
        exp_q.delete();
        t_q.delete();
        base_out = n_out;
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2 * NSEG + 2) step();
        check_eq("rst_none_emerge", 66'(n_out - base_out), 66'd0);
        lat_chk = 1'b1;

        // Parameter sweep
        sweep_go = 1'b1;
        all_done = 1'b0;
        for (int i = 0; i < 2000 && !all_done; i++) begin
            @(posedge clk);
            all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done;
        end
        check_eq("sweep_done", 66'(all_done), 66'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
